exu_issue_ctrl: RTL

//  Issue controller between ID and EXU of the in-order core: holds the EXU input handshake, detects RAW hazards

---
 rtl/exu_issue_ctrl_pkg.sv | 25 ++
 rtl/exu_issue_ctrl_if.sv | 37 +++
 rtl/exu_issue_ctrl_tag_fifo.sv | 83 ++++++++
 rtl/exu_issue_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/exu_issue_ctrl_pkg.sv
// Shared definitions for the EXU issue controller: FSM encodings, default sizing,
// tag FIFO entry layout and tag-width helper.
package exu_issue_ctrl_pkg;

    localparam int DEFAULT_DEPTH        = 4;
    localparam int DEFAULT_FLUSH_CYCLES = 2;
    localparam int REG_W                = 5;

    typedef enum logic [1:0] {
        ISSUE_RUN   = 2'd0,
        ISSUE_DRAIN = 2'd1,
        ISSUE_FLUSH = 2'd2
    } issue_state_e;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             wen;
    } tag_entry_t;

    // Tag = slot index plus one wrap bit, so full and empty stay distinguishable.
    function automatic int tag_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/exu_issue_ctrl_if.sv
// ID/EXU/WB handshake bundle of the issue controller; slave = controller, master = pipeline side.
interface exu_issue_ctrl_if import exu_issue_ctrl_pkg::*; #(
    parameter int DEPTH = DEFAULT_DEPTH
);
    localparam int TAG_W = tag_width(DEPTH);

    logic             id_valid;
    logic             id_ready;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [REG_W-1:0] id_rd;
    logic             id_R_wen;
    logic             id_serial;
    logic             ex_valid;
    logic             ex_ready;
    logic [TAG_W-1:0] ex_tag;
    logic             wb_valid;
    logic             redirect_valid;
    logic [TAG_W-1:0] redirect_tag;
    logic             inst_clear;
    logic             raw_stall;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_R_wen, id_serial,
        output ex_ready, wb_valid, redirect_valid, redirect_tag,
        input  id_ready, ex_valid, ex_tag, inst_clear, raw_stall
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_R_wen, id_serial,
        input  ex_ready, wb_valid, redirect_valid, redirect_tag,
        output id_ready, ex_valid, ex_tag, inst_clear, raw_stall
    );

endinterface

// File: rtl/exu_issue_ctrl_tag_fifo.sv
// In-order tag FIFO of issued-not-retired instructions: push at tail, pop at head,
// truncate-after-tag on redirect, combinational source-register match against live entries.
module issue_tag_fifo import exu_issue_ctrl_pkg::*; #(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int TAG_W = tag_width(DEPTH),
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [REG_W-1:0] push_rd,
    input  logic             push_wen,
    input  logic             pop,
    input  logic             trunc,
    input  logic [TAG_W-1:0] trunc_tag,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    output logic [TAG_W-1:0] tail_tag,
    output logic             full,
    output logic             empty,
    output logic             rs1_hit,
    output logic             rs2_hit
);

    tag_entry_t       mem [DEPTH];
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W-1:0] count;
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] hit1;
    logic [DEPTH-1:0] hit2;

    assign count    = tail - head;
    assign full     = (count == TAG_W'(DEPTH));
    assign empty    = (head == tail);
    assign tail_tag = tail;

    // NOTE: sequential state uses <= so every register samples pre-edge values; = here would race readers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (pop)
                head <= head + TAG_W'(1);
            if (trunc)
                tail <= trunc_tag + TAG_W'(1);
            else if (push)
                tail <= tail + TAG_W'(1);
        end
    end

    // NOTE: payload storage is deliberately not reset; liveness comes only from head/tail.
    always_ff @(posedge clk) begin
        if (push)
            mem[tail[IDX_W-1:0]] <= '{rd: push_rd, wen: push_wen};
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [IDX_W-1:0] offs;
        assign offs    = IDX_W'(g) - head[IDX_W-1:0];
        assign live[g] = ({1'b0, offs} < count);
        assign hit1[g] = live[g] & mem[g].wen & (mem[g].rd == rs1);
        assign hit2[g] = live[g] & mem[g].wen & (mem[g].rd == rs2);
    end

    assign rs1_hit = |hit1;
    assign rs2_hit = |hit2;

    // Upstream protocol: only live entries retire or redirect, and issue never overlaps a redirect.
    logic [TAG_W-1:0] trunc_offs;
    assign trunc_offs = trunc_tag - head;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            a_pop_empty:   assert (!(pop && empty));
            a_trunc_live:  assert (!trunc || (trunc_offs < count));
            a_push_full:   assert (!(push && full));
            a_push_trunc:  assert (!(push && trunc));
        end
    end

endmodule

// File: rtl/exu_issue_ctrl.sv
// EXU issue controller: RAW/serialisation/full gating, redirect flush sequencing, tag FIFO.
// Optional ISSUE_CTRL_PERF_EN adds saturating perf_raw_stall / perf_flush counters.
module exu_issue_ctrl import exu_issue_ctrl_pkg::*; #(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    exu_issue_ctrl_if.slave  bus
`ifdef ISSUE_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_raw_stall,
    output logic [31:0]      perf_flush
`endif
);

    localparam int TAG_W = tag_width(DEPTH);
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

    issue_state_e     state;
    issue_state_e     state_n;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] flush_cnt_n;
    logic             ex_valid_c;
    logic             id_ready_c;
    logic             ex_valid;
    logic             fire;
    logic             hazard;
    logic             full;
    logic             empty;
    logic             rs1_hit;
    logic             rs2_hit;
    logic [TAG_W-1:0] tail_tag;

    issue_tag_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fire),
        .push_rd   (bus.id_rd),
        .push_wen  (bus.id_R_wen & (bus.id_rd != '0)),
        .pop       (bus.wb_valid),
        .trunc     (bus.redirect_valid),
        .trunc_tag (bus.redirect_tag),
        .rs1       (bus.id_rs1),
        .rs2       (bus.id_rs2),
        .tail_tag  (tail_tag),
        .full      (full),
        .empty     (empty),
        .rs1_hit   (rs1_hit),
        .rs2_hit   (rs2_hit)
    );

    // No WB->ID bypass: a writer keeps blocking through its own retire cycle.
    assign hazard = (bus.id_rs1_used & rs1_hit) | (bus.id_rs2_used & rs2_hit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ISSUE_RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_n;
            flush_cnt <= flush_cnt_n;
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_n     = state;
        flush_cnt_n = flush_cnt;
        ex_valid_c  = 1'b0;
        id_ready_c  = 1'b0;
        case (state)
            ISSUE_RUN: begin
                ex_valid_c = bus.id_valid & ~hazard & ~full & ~(bus.id_serial & ~empty)
                           & ~bus.redirect_valid;
                id_ready_c = ex_valid_c & bus.ex_ready;
                if (bus.redirect_valid) begin
                    state_n     = ISSUE_FLUSH;
                    flush_cnt_n = '0;
                end else if (bus.id_valid & bus.id_serial & ~empty) begin
                    state_n = ISSUE_DRAIN;
                end
            end
            ISSUE_DRAIN: begin
                if (bus.redirect_valid) begin
                    state_n     = ISSUE_FLUSH;
                    flush_cnt_n = '0;
                end else if (empty) begin
                    state_n = ISSUE_RUN;
                end
            end
            ISSUE_FLUSH: begin
                // Wrong-path instructions are consumed and dropped.
                id_ready_c = bus.id_valid;
                if (bus.redirect_valid) begin
                    flush_cnt_n = '0;
                end else if (flush_cnt == FLUSH_LAST) begin
                    state_n     = ISSUE_RUN;
                    flush_cnt_n = '0;
                end else begin
                    flush_cnt_n = flush_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n     = ISSUE_RUN;
                flush_cnt_n = '0;
            end
        endcase
    end

    // Outputs stay quiet while reset is held, whatever ID presents.
    assign ex_valid       = rst_n & ex_valid_c;
    assign fire           = ex_valid & bus.ex_ready;
    assign bus.ex_valid   = ex_valid;
    assign bus.id_ready   = rst_n & id_ready_c;
    assign bus.ex_tag     = tail_tag;
    assign bus.inst_clear = rst_n & bus.redirect_valid;
    assign bus.raw_stall  = rst_n & (state == ISSUE_RUN) & bus.id_valid & hazard;

`ifdef ISSUE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_raw_stall <= '0;
            perf_flush     <= '0;
        end else begin
            if (bus.raw_stall && (perf_raw_stall != 32'hFFFF_FFFF))
                perf_raw_stall <= perf_raw_stall + 32'd1;
            if (bus.redirect_valid && (perf_flush != 32'hFFFF_FFFF))
                perf_flush <= perf_flush + 32'd1;
        end
    end
`endif

endmodule
